// File: rtl/writeback_queue.sv
// Register-file writeback queue: buffers ALU/load write requests, drains one per
// cycle into the register file write port, and forwards the youngest pending value.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_reg,
    input  logic [31:0]              alu_data,
    input  logic                     mem_valid,
    input  logic [4:0]               mem_reg,
    input  logic [31:0]              mem_data,
    input  logic [4:0]               read1,
    input  logic [4:0]               read2,
    output logic                     stall,
    output logic                     RegWrite,
    output logic [4:0]               write_reg,
    output logic [31:0]              write_data,
    output logic                     fwd1_hit,
    output logic [31:0]              fwd1_data,
    output logic                     fwd2_hit,
    output logic [31:0]              fwd2_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic              r_valid [DEPTH];
    logic [4:0]        r_reg   [DEPTH];
    logic [31:0]       r_data  [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_wr_en;
    logic [4:0]        r_wr_reg;
    logic [31:0]       r_wr_data;
    logic              r_overflow;

    logic              w_pop;
    logic [CW-1:0]     w_free;
    logic              w_mem_req;
    logic              w_alu_req;
    logic              w_mem_acc;
    logic              w_alu_acc;
    logic              w_drop;
    logic [CW-1:0]     w_n_acc;
    logic [PW-1:0]     w_alu_slot;
    logic [DEPTH-1:0]  w_match1;
    logic [DEPTH-1:0]  w_match2;

    // The head slot retiring this edge counts as free space for incoming requests.
    assign w_pop      = (r_count != '0);
    assign w_free     = CW'(DEPTH) - r_count + CW'(w_pop);
    assign w_mem_req  = mem_valid && (mem_reg != 5'd0);
    assign w_alu_req  = alu_valid && (alu_reg != 5'd0);
    assign w_mem_acc  = w_mem_req && (w_free != '0);
    assign w_alu_acc  = w_alu_req && (w_free > CW'(w_mem_acc));
    assign w_drop     = (w_mem_req && !w_mem_acc) || (w_alu_req && !w_alu_acc);
    assign w_n_acc    = CW'(w_mem_acc) + CW'(w_alu_acc);
    assign w_alu_slot = w_mem_acc ? (r_tail + PW'(1)) : r_tail;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_wr_en    <= 1'b0;
            r_wr_reg   <= '0;
            r_wr_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_wr_en         <= 1'b1;
                r_wr_reg        <= r_reg[r_head];
                r_wr_data       <= r_data[r_head];
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end else begin
                r_wr_en <= 1'b0;
            end
            // Pushes follow the pop so a push into the just-freed head slot wins.
            if (w_mem_acc) begin
                r_valid[r_tail] <= 1'b1;
                r_reg[r_tail]   <= mem_reg;
                r_data[r_tail]  <= mem_data;
            end
            if (w_alu_acc) begin
                r_valid[w_alu_slot] <= 1'b1;
                r_reg[w_alu_slot]   <= alu_reg;
                r_data[w_alu_slot]  <= alu_data;
            end
            r_tail  <= r_tail + PW'(w_n_acc);
            r_count <= r_count - CW'(w_pop) + w_n_acc;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_match1[gi] = r_valid[gi] && (r_reg[gi] == read1);
            assign w_match2[gi] = r_valid[gi] && (r_reg[gi] == read2);
        end
    endgenerate

    // Output stage is the oldest candidate; walking oldest-to-youngest lets the youngest match win.
    always_comb begin
        logic [PW-1:0] w_idx;
        w_idx     = '0;
        fwd1_hit  = r_wr_en && (r_wr_reg == read1);
        fwd1_data = fwd1_hit ? r_wr_data : 32'd0;
        fwd2_hit  = r_wr_en && (r_wr_reg == read2);
        fwd2_data = fwd2_hit ? r_wr_data : 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (w_match1[w_idx]) begin
                fwd1_hit  = 1'b1;
                fwd1_data = r_data[w_idx];
            end
            if (w_match2[w_idx]) begin
                fwd2_hit  = 1'b1;
                fwd2_data = r_data[w_idx];
            end
        end
        if (read1 == 5'd0) begin
            fwd1_hit  = 1'b0;
            fwd1_data = 32'd0;
        end
        if (read2 == 5'd0) begin
            fwd2_hit  = 1'b0;
            fwd2_data = 32'd0;
        end
    end

    assign stall      = (r_count > CW'(DEPTH - 2));
    assign count      = r_count;
    assign RegWrite   = r_wr_en;
    assign write_reg  = r_wr_reg;
    assign write_data = r_wr_data;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_writeback_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_reg, mem_reg, read1, read2;
    logic [31:0] alu_data, mem_data;
    logic        stall, RegWrite, fwd1_hit, fwd2_hit, overflow;
    logic [4:0]  write_reg;
    logic [31:0] write_data, fwd1_data, fwd2_data;
    logic [2:0]  count;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
        .read1(read1), .read2(read2),
        .stall(stall), .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } entry_t;

    entry_t      mq[$];
    logic        m_rw = 1'b0;
    logic [4:0]  m_wr = '0;
    logic [31:0] m_wd = '0;
    logic        m_ovf = 1'b0;
    bit          m_known = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic void exp_fwd(input logic [4:0] rd, output logic hit, output logic [31:0] data);
        hit = 1'b0;
        data = 32'd0;
        if (rd == 5'd0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].r == rd) begin
                hit = 1'b1;
                data = mq[i].d;
                return;
            end
        end
        if (m_rw && m_wr == rd) begin
            hit = 1'b1;
            data = m_wd;
        end
    endfunction

    task automatic compare_model();
        logic h;
        logic [31:0] d;
        if (!m_known) return;
        chk("count", 32'(count), 32'(mq.size()));
        chk("stall", 32'(stall), 32'((DEPTH - mq.size()) < 2));
        chk("RegWrite", 32'(RegWrite), 32'(m_rw));
        chk("write_reg", 32'(write_reg), 32'(m_wr));
        chk("write_data", write_data, m_wd);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        exp_fwd(read1, h, d);
        chk("fwd1_hit", 32'(fwd1_hit), 32'(h));
        chk("fwd1_data", fwd1_data, d);
        exp_fwd(read2, h, d);
        chk("fwd2_hit", 32'(fwd2_hit), 32'(h));
        chk("fwd2_data", fwd2_data, d);
    endtask

    task automatic model_edge();
        entry_t e;
        if (!rst) begin
            mq.delete();
            m_rw = 1'b0; m_wr = '0; m_wd = '0; m_ovf = 1'b0;
            m_known = 1'b1;
            return;
        end
        if (!m_known) return;
        if (mq.size() > 0) begin
            e = mq.pop_front();
            m_rw = 1'b1; m_wr = e.r; m_wd = e.d;
        end else begin
            m_rw = 1'b0;
        end
        if (mem_valid && mem_reg != 5'd0) begin
            e.r = mem_reg; e.d = mem_data;
            if (mq.size() < DEPTH) mq.push_back(e); else m_ovf = 1'b1;
        end
        if (alu_valid && alu_reg != 5'd0) begin
            e.r = alu_reg; e.d = alu_data;
            if (mq.size() < DEPTH) mq.push_back(e); else m_ovf = 1'b1;
        end
    endtask

    // Called at a negedge with inputs already driven: compare, take the edge, return at next negedge.
    task automatic tick();
        #1;
        compare_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic av, input logic [4:0] ar, input logic [31:0] ad);
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        logic [4:0] exp_wr [4];
        rst = 1'b0; read1 = 5'd7; read2 = 5'd0;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);

        // Reset held two edges with a live request
        tick(); tick();
        rst = 1'b1; idle(); read1 = 5'd7;
        #1;
        chk("rst_RegWrite", 32'(RegWrite), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);

        // Single write
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF); read1 = 5'd5;
        tick();
        idle();
        #1;
        chk("single_count", 32'(count), 32'd1);
        chk("single_fwd_hit", 32'(fwd1_hit), 32'd1);
        chk("single_fwd_data", fwd1_data, 32'hDEADBEEF);
        tick();
        #1;
        chk("single_RegWrite", 32'(RegWrite), 32'd1);
        chk("single_write_reg", 32'(write_reg), 32'd5);
        chk("single_write_data", write_data, 32'hDEADBEEF);
        chk("single_outstage_hit", 32'(fwd1_hit), 32'd1);
        tick();
        #1;
        chk("single_RegWrite_off", 32'(RegWrite), 32'd0);
        chk("single_fwd_gone", 32'(fwd1_hit), 32'd0);

        // Same-cycle mem and alu to the same register
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22); read1 = 5'd3;
        tick();
        idle();
        #1;
        chk("order_fwd_young", fwd1_data, 32'h22);
        tick();
        #1;
        chk("order_first_write", write_data, 32'h11);
        chk("order_fwd_mid", fwd1_data, 32'h22);
        tick();
        #1;
        chk("order_second_write", write_data, 32'h22);
        chk("order_fwd_last", fwd1_data, 32'h22);
        tick();
        #1;
        chk("order_fwd_done", 32'(fwd1_hit), 32'd0);

        // Register 0 discarded
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55); read1 = 5'd0;
        tick();
        idle();
        #1;
        chk("r0_count", 32'(count), 32'd0);
        chk("r0_hit", 32'(fwd1_hit), 32'd0);
        chk("r0_data", fwd1_data, 32'd0);
        tick();
        #1;
        chk("r0_RegWrite", 32'(RegWrite), 32'd0);

        // Sustained dual pushes into overflow
        drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd2, 32'h200);
        tick();
        drive(1'b1, 5'd3, 32'h300, 1'b1, 5'd4, 32'h400);
        #1;
        chk("ovf_count2", 32'(count), 32'd2);
        chk("ovf_stall0", 32'(stall), 32'd0);
        tick();
        drive(1'b1, 5'd5, 32'h500, 1'b1, 5'd6, 32'h600);
        #1;
        chk("ovf_count3", 32'(count), 32'd3);
        chk("ovf_stall1", 32'(stall), 32'd1);
        chk("ovf_wr1", 32'(write_reg), 32'd1);
        tick();
        drive(1'b1, 5'd7, 32'h700, 1'b1, 5'd8, 32'h800);
        #1;
        chk("ovf_count4", 32'(count), 32'd4);
        chk("ovf_wr2", 32'(write_reg), 32'd2);
        tick();
        idle();
        #1;
        chk("ovf_count_full", 32'(count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_wr3", 32'(write_reg), 32'd3);
        exp_wr[0] = 5'd4; exp_wr[1] = 5'd5; exp_wr[2] = 5'd6; exp_wr[3] = 5'd7;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("drain_wr", 32'(write_reg), 32'(exp_wr[i]));
        end
        tick();
        #1;
        chk("drain_done", 32'(RegWrite), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset with three entries queued
        drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'hA);
        tick();
        drive(1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC);
        tick();
        rst = 1'b0; idle(); read1 = 5'd12; read2 = 5'd11;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_RegWrite", 32'(RegWrite), 32'd0);
        chk("mid_rst_fwd1", 32'(fwd1_hit), 32'd0);
        chk("mid_rst_fwd2", 32'(fwd2_hit), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("mid_rst_quiet", 32'(RegWrite), 32'd0);
        end

        // Randomized traffic, mostly honouring stall
        for (int c = 0; c < 3000; c++) begin
            bit obey;
            bit st;
            obey = ($urandom_range(0, 9) != 0);
            st = ((DEPTH - mq.size()) < 2);
            rst = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
            if (obey && st) begin
                mem_valid = 1'b0;
                alu_valid = 1'b0;
            end
            read1 = 5'($urandom_range(0, 7));
            read2 = 5'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b1; idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffers register-file write requests from the ALU and load paths and drains them one per cycle into the register file write port (RegWrite / write_reg / write_data). It sits between the execute/memory stages and the 32×32 register file, so it is the writing end of that interface. It also forwards the youngest pending value for the two read addresses, so decode never sees stale data while a write is queued or in flight.

## Interface
- DEPTH, 4, queue entries; power of two, ≥ 2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous and active-low
- alu_valid  in  1  ALU writeback request this cycle
- alu_reg  in  5  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  load writeback request this cycle
- mem_reg  in  5  load destination register
- mem_data  in  32  load data
- read1, read2  in  5 each  register numbers being read by decode
- stall  out  1  combinational; producers must not assert valid while high
- RegWrite  out  1  registered; write strobe to register file
- write_reg  out  5  registered; register file write address
- write_data  out  32  registered; register file write data
- fwd1_hit, fwd2_hit  out  1 each  combinational; pending value exists for read1/read2
- fwd1_data, fwd2_data  out  32 each  combinational; forwarded value, 0 when no hit
- count  out  $clog2(DEPTH)+1  stored entries
- overflow  out  1  sticky; a request was dropped

## Operation
- Circular FIFO: head/tail pointers, one valid bit per entry.
- Writes to register 0 are discarded at input: never enqueued, never counted, never set overflow.
- Same-cycle mem and alu requests: mem entry is older and enqueued first, alu entry second.
- Pop: on each edge with count > 0, the head entry loads into RegWrite/write_reg/write_data with RegWrite=1. With count = 0, RegWrite=0 and write_reg/write_data hold their previous values.
- Free slots on an edge = DEPTH − count + (count > 0 ? 1 : 0). Push and pop in the same edge are allowed.
- Requests are accepted in age order while free slots remain. Any request that does not fit is dropped and overflow sets to 1. overflow clears only on reset.
- stall = (DEPTH − count) < 2.
- Forwarding for each read port, with readN ≠ 0: search the youngest queue entry first, then older entries, then the output stage (RegWrite=1 and write_reg match). The first match gives hit=1 and its data. readN = 0 gives hit=0, data=0.
- Same-cycle incoming requests are not forwarded.

## Timing
- Reset (rst=0 at an edge): queue empty, count=0, RegWrite=0, write_reg=0, write_data=0, overflow=0. Any pending entries are discarded.
- Reset overrides simultaneous valid inputs.
- Latency: a request accepted at edge N is visible to forwarding and count after edge N. With an empty queue, RegWrite pulses for the cycle after edge N+1.
- Throughput: one write per cycle. A sustained dual push grows count by 1 per cycle.
- The output stage stays visible to forwarding for the one cycle RegWrite is high. This covers the register file's registered read, which returns the old value on the write edge.
- Wrap-around: pointers wrap modulo DEPTH. count distinguishes full from empty.
- Full queue (count=DEPTH) with a dual push: the pop frees one slot, so mem is accepted, alu is dropped, overflow=1, and count stays DEPTH.

## Test plan
- Reset: hold rst=0 for 2 cycles with alu_valid=1, alu_reg=7 -> RegWrite=0, count=0, overflow=0, fwd1_hit=0 for read1=7.
- Single write: alu reg 5, data 0xDEADBEEF at edge 1 -> after edge 1, count=1 and read1=5 gives fwd1_hit=1, fwd1_data=0xDEADBEEF. After edge 2: RegWrite=1, write_reg=5, write_data=0xDEADBEEF, fwd still hits. After edge 3: RegWrite=0, fwd1_hit=0.
- Ordering: same-cycle mem(3, 0x11) and alu(3, 0x22) -> write order is 0x11 then 0x22. fwd returns 0x22 until the last write retires.
- Register 0: alu_valid with alu_reg=0, data 0x55 -> count stays 0, RegWrite never asserts, read1=0 gives hit=0, data=0.
- Overflow (DEPTH=4): dual pushes to regs 1..8 every cycle -> stall=1 once count≥3. Forcing a dual push at count=4 gives mem accepted, alu dropped, overflow=1 and sticky, count=4. Drain order matches acceptance order.
- Reset mid-operation: 3 entries queued, rst=0 for one edge -> count=0, RegWrite=0, all fwd hits 0. No queued write appears after reset is released.
